// File: rtl/acc_pkg.sv
// Shared FSRCNN accelerator definitions: the top-level state encoding seen by
// the loader, compute array and output writer.
package acc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_STORE   = 3'd3,
    ST_DONE    = 3'd4
  } acc_state_e;

endpackage

// File: rtl/acc_sched_ctrl_if.sv
// Control/status bundle between the host-side sequencing inputs and acc_sched_ctrl.
// The controller takes the slave view; the host/bench drives through master.
interface acc_sched_ctrl_if #(
  parameter int AW = 8,
  parameter int LW = 4,
  parameter int TW = 8
);
  logic          start;
  logic          abort;
  logic [LW-1:0] cfg_layers;
  logic [TW-1:0] cfg_tiles;
  logic [AW-1:0] cfg_words;
  logic          dl_finish_flg;
  logic          compute_done;
  logic          store_done;

  logic [2:0]    top_level_state;
  logic [AW-1:0] base_a_ra;
  logic [AW-1:0] num_a_rd;
  logic          compute_start;
  logic          store_start;
  logic [LW-1:0] layer_idx;
  logic [TW-1:0] tile_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, cfg_layers, cfg_tiles, cfg_words,
           dl_finish_flg, compute_done, store_done,
    input  top_level_state, base_a_ra, num_a_rd, compute_start, store_start,
           layer_idx, tile_idx, busy, done
  );

  modport slave (
    input  start, abort, cfg_layers, cfg_tiles, cfg_words,
           dl_finish_flg, compute_done, store_done,
    output top_level_state, base_a_ra, num_a_rd, compute_start, store_start,
           layer_idx, tile_idx, busy, done
  );
endinterface

// File: rtl/acc_sched_ctrl.sv
// Top-level FSRCNN sequencer: walks layers x tiles through LOAD -> COMPUTE -> STORE,
// driving the shared state bus and the loader's ping-pong base address. All outputs registered.
module acc_sched_ctrl
  import acc_pkg::*;
#(
  parameter int AW = 8,
  parameter int LW = 4,
  parameter int TW = 8
) (
  input  logic             clk,
  input  logic             rst,
  acc_sched_ctrl_if.slave  bus
);

  localparam logic [AW-1:0] HALF_BASE = AW'(1) << (AW - 1);

  acc_state_e    state;
  logic [LW-1:0] layers_q;
  logic [TW-1:0] tiles_q;
  logic [AW-1:0] words_q;
  logic [LW-1:0] layer_idx;
  logic [TW-1:0] tile_idx;
  logic [AW-1:0] base_q;
  logic          pp;
  logic          ld_arm;
  logic          compute_start;
  logic          store_start;
  logic          busy;
  logic          done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      layers_q      <= '0;
      tiles_q       <= '0;
      words_q       <= '0;
      layer_idx     <= '0;
      tile_idx      <= '0;
      base_q        <= '0;
      pp            <= 1'b0;
      ld_arm        <= 1'b0;
      compute_start <= 1'b0;
      store_start   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      compute_start <= 1'b0;
      store_start   <= 1'b0;
      done          <= 1'b0;
      if (bus.abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.start) begin
              state     <= ST_LOAD;
              busy      <= 1'b1;
              layers_q  <= bus.cfg_layers;
              tiles_q   <= bus.cfg_tiles;
              words_q   <= bus.cfg_words;
              layer_idx <= '0;
              tile_idx  <= '0;
              pp        <= 1'b0;
              base_q    <= '0;
              ld_arm    <= 1'b0;
            end
          end
          ST_LOAD: begin
            // The loader clears its counter a cycle late, so the first LOAD
            // cycle may still see the previous tile's finish flag.
            ld_arm <= 1'b1;
            if (bus.dl_finish_flg && ld_arm) begin
              state         <= ST_COMPUTE;
              compute_start <= 1'b1;
            end
          end
          ST_COMPUTE: begin
            if (bus.compute_done) begin
              state       <= ST_STORE;
              store_start <= 1'b1;
            end
          end
          ST_STORE: begin
            if (bus.store_done) begin
              if (tile_idx < tiles_q || layer_idx < layers_q) begin
                if (tile_idx < tiles_q) begin
                  tile_idx <= tile_idx + TW'(1);
                end else begin
                  layer_idx <= layer_idx + LW'(1);
                  tile_idx  <= '0;
                end
                // Base follows the toggled pp: the new half is the one not just loaded.
                pp     <= ~pp;
                base_q <= pp ? '0 : HALF_BASE;
                ld_arm <= 1'b0;
                state  <= ST_LOAD;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.top_level_state = state;
  assign bus.base_a_ra       = base_q;
  assign bus.num_a_rd        = words_q;
  assign bus.compute_start   = compute_start;
  assign bus.store_start     = store_start;
  assign bus.layer_idx       = layer_idx;
  assign bus.tile_idx        = tile_idx;
  assign bus.busy            = busy;
  assign bus.done            = done;

endmodule

// File: tb/tb_acc_sched_ctrl.sv
// Self-checking bench for acc_sched_ctrl: config table, directed corner cases and
// randomized jobs checked against an expected tile list built from layer/tile arithmetic.
module tb_acc_sched_ctrl;
  import acc_pkg::*;

  localparam int AW   = 8;
  localparam int LW   = 4;
  localparam int TW   = 8;
  localparam int HALF = 1 << (AW - 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_sched_ctrl_if #(.AW(AW), .LW(LW), .TW(TW)) bus ();

  acc_sched_ctrl #(.AW(AW), .LW(LW), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Pulse and state-change monitor
  int   cs_cnt = 0, ss_cnt = 0, dn_cnt = 0, ld_cnt = 0;
  logic [2:0] prev_st = 3'd0;
  int   seq[$];
  always @(negedge clk) begin
    if (bus.compute_start === 1'b1) cs_cnt++;
    if (bus.store_start === 1'b1)   ss_cnt++;
    if (bus.done === 1'b1)          dn_cnt++;
    if (bus.top_level_state !== prev_st) begin
      seq.push_back(int'(bus.top_level_state));
      if (bus.top_level_state === ST_LOAD) ld_cnt++;
    end
    prev_st = bus.top_level_state;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, bus.top_level_state, 0);
    chk({tag, "_base"},  bus.base_a_ra, 0);
    chk({tag, "_num"},   bus.num_a_rd, 0);
    chk({tag, "_cs"},    bus.compute_start, 0);
    chk({tag, "_ss"},    bus.store_start, 0);
    chk({tag, "_layer"}, bus.layer_idx, 0);
    chk({tag, "_tile"},  bus.tile_idx, 0);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
  endtask

  // Runs one job. Negative delays mean random. abort_k >= 0 aborts in COMPUTE of that tile.
  task automatic run_job(input int L, input int T, input int W,
                         input int ld_d, input int cp_d, input int st_d, input int abort_k);
    int n, cs0, ss0, dn0, d, c, s, lexp, el, et, eb;
    bit stale;
    n   = (L + 1) * (T + 1);
    cs0 = cs_cnt; ss0 = ss_cnt; dn0 = dn_cnt;
    bus.cfg_layers = LW'(L);
    bus.cfg_tiles  = TW'(T);
    bus.cfg_words  = AW'(W);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.cfg_layers = LW'($urandom);
    bus.cfg_tiles  = TW'($urandom);
    bus.cfg_words  = AW'($urandom);
    for (int k = 0; k < n; k++) begin
      el = k / (T + 1);
      et = k % (T + 1);
      eb = (k % 2 == 1) ? HALF : 0;
      chk("load_entry", bus.top_level_state, ST_LOAD);
      chk("layer_idx", bus.layer_idx, el);
      chk("tile_idx", bus.tile_idx, et);
      chk("base_a_ra", bus.base_a_ra, eb);
      chk("num_a_rd", bus.num_a_rd, W);
      chk("busy_load", bus.busy, 1);
      d     = (ld_d >= 0) ? ld_d : int'($urandom_range(0, 4));
      stale = (d >= 1) && ($urandom_range(0, 1) == 1);
      lexp  = (d == 0) ? 2 : d + 1;
      for (int j = 1; j <= lexp; j++) begin
        bus.dl_finish_flg = (j == lexp) || (j == 1 && (stale || d == 0));
        bus.compute_done  = 1'($urandom_range(0, 1));
        bus.store_done    = 1'($urandom_range(0, 1));
        tick();
        if (j < lexp) begin
          chk("load_hold", bus.top_level_state, ST_LOAD);
          chk("base_stable", bus.base_a_ra, eb);
        end
      end
      bus.dl_finish_flg = 1'($urandom_range(0, 1));
      bus.compute_done  = 1'b0;
      bus.store_done    = 1'b0;
      chk("compute_entry", bus.top_level_state, ST_COMPUTE);
      chk("compute_start", bus.compute_start, 1);
      if (k == abort_k) begin
        bus.abort = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("abort_state", bus.top_level_state, ST_IDLE);
        chk("abort_busy", bus.busy, 0);
        chk("abort_layer_hold", bus.layer_idx, el);
        chk("abort_tile_hold", bus.tile_idx, et);
        tick();
        bus.abort = 1'b0;
        chk("abort_start_masked", bus.top_level_state, ST_IDLE);
        tick();
        chk("abort_no_done", dn_cnt - dn0, 0);
        bus.dl_finish_flg = 1'b0;
        return;
      end
      c = (cp_d >= 0) ? cp_d : int'($urandom_range(0, 5));
      for (int i = 0; i < c; i++) begin
        bus.start      = (i == 0);
        bus.store_done = 1'($urandom_range(0, 1));
        tick();
        bus.start = 1'b0;
        chk("compute_hold", bus.top_level_state, ST_COMPUTE);
        chk("compute_start_once", bus.compute_start, 0);
      end
      bus.store_done    = 1'b0;
      bus.dl_finish_flg = 1'b0;
      bus.compute_done  = 1'b1;
      tick();
      bus.compute_done = 1'b0;
      chk("store_entry", bus.top_level_state, ST_STORE);
      chk("store_start", bus.store_start, 1);
      s = (st_d >= 0) ? st_d : int'($urandom_range(0, 4));
      for (int i = 0; i < s; i++) begin
        bus.compute_done  = 1'($urandom_range(0, 1));
        bus.dl_finish_flg = 1'($urandom_range(0, 1));
        tick();
        chk("store_hold", bus.top_level_state, ST_STORE);
      end
      bus.compute_done  = 1'b0;
      bus.dl_finish_flg = 1'b0;
      bus.store_done    = 1'b1;
      tick();
      bus.store_done = 1'b0;
    end
    chk("done_state", bus.top_level_state, ST_DONE);
    chk("done_pulse", bus.done, 1);
    tick();
    chk("idle_after_done", bus.top_level_state, ST_IDLE);
    chk("done_one_cycle", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
    chk("final_layer", bus.layer_idx, L);
    chk("final_tile", bus.tile_idx, T);
    chk("cs_count", cs_cnt - cs0, n);
    chk("ss_count", ss_cnt - ss0, n);
    chk("done_count", dn_cnt - dn0, 1);
  endtask

  typedef struct {
    int layers;
    int tiles;
    int words;
    int exp_loads;
    int exp_last_base;
  } vec_t;

  vec_t tbl[6];
  int   ld0;
  int   exp_seq[5];

  initial begin
    tbl[0] = '{0, 0, 3, 1, 0};
    tbl[1] = '{1, 2, 0, 6, 128};
    tbl[2] = '{2, 1, 7, 6, 128};
    tbl[3] = '{0, 3, 255, 4, 128};
    tbl[4] = '{3, 0, 1, 4, 128};
    tbl[5] = '{0, 2, 17, 3, 0};
    exp_seq = '{1, 2, 3, 4, 0};

    bus.start = 1'b0; bus.abort = 1'b0;
    bus.cfg_layers = '0; bus.cfg_tiles = '0; bus.cfg_words = '0;
    bus.dl_finish_flg = 1'b0; bus.compute_done = 1'b0; bus.store_done = 1'b0;

    // Reset held three cycles, then idle with start low
    rst = 1'b1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_no_start", bus.top_level_state, ST_IDLE);

    // Single tile: finish flag on 5th LOAD cycle, 10 COMPUTE cycles, 4 STORE cycles
    seq.delete();
    run_job(0, 0, 3, 4, 9, 3, -1);
    chk("seq_len", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("seq_state", seq[i], exp_seq[i]);
    chk("single_base", bus.base_a_ra, 0);
    chk("single_num", bus.num_a_rd, 3);

    // Minimum-length LOAD with single-word tiles and a held finish flag
    run_job(0, 1, 0, 0, 1, 0, -1);

    // Config table
    for (int r = 0; r < 6; r++) begin
      ld0 = ld_cnt;
      run_job(tbl[r].layers, tbl[r].tiles, tbl[r].words, -1, -1, -1, -1);
      chk("tbl_loads", ld_cnt - ld0, tbl[r].exp_loads);
      chk("tbl_last_base", bus.base_a_ra, tbl[r].exp_last_base);
    end

    // Abort in COMPUTE of tile 1, then restart with fresh config
    run_job(1, 2, 5, -1, -1, -1, 1);
    run_job(0, 1, 9, -1, -1, -1, -1);

    // Reset during STORE
    bus.cfg_layers = 4'd1; bus.cfg_tiles = 8'd1; bus.cfg_words = 8'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.dl_finish_flg = 1'b1;
    repeat (2) tick();
    bus.dl_finish_flg = 1'b0;
    bus.compute_done = 1'b1;
    tick();
    bus.compute_done = 1'b0;
    chk("pre_rst_store", bus.top_level_state, ST_STORE);
    rst = 1'b1;
    tick();
    chk_all_zero("mid_rst");
    rst = 1'b0;
    tick();
    chk("post_rst_idle", bus.top_level_state, ST_IDLE);

    // Randomized jobs, occasionally aborted
    for (int r = 0; r < 10; r++) begin
      int L, T, ab;
      L  = int'($urandom_range(0, 2));
      T  = int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (L + 1) * (T + 1) - 1)) : -1;
      run_job(L, T, int'($urandom_range(0, 255)), -1, -1, -1, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
